obi_mem_responder: RTL and testbench

- Memory-side responder for the core's req/gnt/rvalid instruction/data bus; the slave end of the protocol that the memory mux drives.
- Backs a word-organised on-chip RAM with byte-enable writes.
- Grant wait states and read latency are programmable, so the bench and FPGA builds can exercise core stall paths.
- One instance per bus port (instruction or data); it sits directly behind the mux outputs, whose addresses are already offset-corrected.

---
 rtl/obi_mem_responder.sv | 124 ++++++++++++
 tb/tb_obi_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid bus: word RAM with byte-enable writes,
// programmable grant wait states and a fixed-latency, in-order response pipe.
module obi_mem_responder #(
    parameter int          MEM_WORDS    = 16384,
    parameter int          GNT_DELAY    = 0,
    parameter int          RVALID_DELAY = 1,
    parameter logic [31:0] OOR_RDATA    = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        stall_i
);

    // state | meaning
    // IDLE  | no request outstanding, wait counter at 0
    // WAIT  | request held without grant, counting wait cycles

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [2:0]  GNT_CNT   = 3'(GNT_DELAY);
    localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

    state_t      state;
    state_t      state_next;
    logic [2:0]  cnt;
    logic [2:0]  cnt_next;

    logic [29:0]   idx;
    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;
    logic          unused_addr;

    logic [31:0] mem [MEM_WORDS];

    logic [RVALID_DELAY-1:0] pipe_valid;
    logic [31:0]             pipe_data [RVALID_DELAY];

    // Full upper-bit compare so out-of-range addresses never alias into the RAM.
    assign idx         = addr_i[31:2];
    assign in_range    = ({1'b0, idx} < MEM_LIMIT);
    assign mem_idx     = idx[AW-1:0];
    assign unused_addr = ^addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Grant is gated by reset so a write racing reset assertion is never committed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gnt_o      = rst_ni & req_i & ~stall_i & (cnt == GNT_CNT);
        if (gnt_o || !req_i) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
        end else begin
            state_next = WAIT;
            if (cnt < GNT_CNT) begin
                cnt_next = cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[mem_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = 32'd0;
        if (!we_i) begin
            rd_word = in_range ? mem[mem_idx] : OOR_RDATA;
        end
    end

    // Data stages only advance behind a valid, so the last stage holds the last response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            for (int k = 0; k < RVALID_DELAY; k++) begin
                pipe_data[k] <= 32'd0;
            end
        end else begin
            pipe_valid[0] <= gnt_o;
            if (gnt_o) begin
                pipe_data[0] <= rd_word;
            end
            for (int k = 1; k < RVALID_DELAY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign rvalid_o = pipe_valid[RVALID_DELAY-1];
    assign rdata_o  = pipe_data[RVALID_DELAY-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: four instances with different wait/latency/size settings,
// scenario tasks with a response scoreboard per scenario.
module tb_obi_mem_responder;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } xfer_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;

    localparam logic [31:0] STALL_PAT [4] = '{32'h1111_1111, 32'h2222_2222,
                                              32'h3333_3333, 32'h4444_4444};

    logic        clk;
    logic        rst_n  [4];
    logic        req    [4];
    logic        gnt    [4];
    logic        rvalid [4];
    logic [31:0] addr   [4];
    logic        we     [4];
    logic [3:0]  be     [4];
    logic [31:0] wdata  [4];
    logic [31:0] rdata  [4];
    logic        stall  [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: default config; u1: grant wait states; u2: long latency; u3: tiny RAM, latency 4
    obi_mem_responder #(.GNT_DELAY(0), .RVALID_DELAY(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]),
        .stall_i(stall[0]));

    obi_mem_responder #(.MEM_WORDS(1024), .GNT_DELAY(3), .RVALID_DELAY(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]),
        .stall_i(stall[1]));

    obi_mem_responder #(.MEM_WORDS(1024), .GNT_DELAY(0), .RVALID_DELAY(3)) u2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
        .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rdata_o(rdata[2]),
        .stall_i(stall[2]));

    obi_mem_responder #(.MEM_WORDS(16), .GNT_DELAY(0), .RVALID_DELAY(4)) u3 (
        .clk_i(clk), .rst_ni(rst_n[3]), .req_i(req[3]), .gnt_o(gnt[3]), .rvalid_o(rvalid[3]),
        .addr_i(addr[3]), .we_i(we[3]), .be_i(be[3]), .wdata_i(wdata[3]), .rdata_o(rdata[3]),
        .stall_i(stall[3]));

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_n[i] = 1'b0;
            req[i]   = 1'b1;
            stall[i] = 1'b0;
            we[i]    = 1'b0;
            be[i]    = 4'h0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
        end
        #3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_state u%0d: gnt=%b rvalid=%b rdata=%h, expected 0/0/0",
                         i, gnt[i], rvalid[i], rdata[i]);
            end
        end
        for (int i = 0; i < 4; i++) req[i] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    endtask

    task automatic test_back_to_back();
        xfer_t list [$];
        sb_t   sb [$];
        int    n = 0;
        logic  exp_rv;
        list.push_back('{32'h0000_0100, 1'b1, 4'hF,    32'h1234_5678, 32'h0});
        list.push_back('{32'h0000_0100, 1'b0, 4'h0,    32'h0,         32'h1234_5678});
        list.push_back('{32'h0000_0040, 1'b1, 4'hF,    32'hAABB_CCDD, 32'h0});
        list.push_back('{32'h0000_0040, 1'b1, 4'b0101, 32'h1122_3344, 32'h0});
        list.push_back('{32'h0000_0040, 1'b0, 4'hF,    32'h0,         32'hAA22_CC44});
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            req[0] = (n < list.size());
            if (req[0]) begin
                addr[0] = list[n].addr; we[0] = list[n].we;
                be[0] = list[n].be; wdata[0] = list[n].wdata;
            end
            @(negedge clk);
            checks++;
            if (gnt[0] !== req[0]) begin
                failures++;
                $display("FAIL b2b_gnt cycle=%0d got=%b expected=%b", c, gnt[0], req[0]);
            end
            exp_rv = (sb.size() > 0) && (sb[0].due == c);
            checks++;
            if (rvalid[0] !== exp_rv) begin
                failures++;
                $display("FAIL b2b_rvalid cycle=%0d got=%b expected=%b", c, rvalid[0], exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rdata[0] !== sb[0].data) begin
                    failures++;
                    $display("FAIL b2b_rdata cycle=%0d got=%h expected=%h", c, rdata[0], sb[0].data);
                end
                void'(sb.pop_front());
            end
            if (req[0] && gnt[0]) begin
                sb.push_back('{c + 1, list[n].exp});
                n++;
            end
            @(posedge clk); #1;
        end
        req[0] = 1'b0;
        checks++;
        if (sb.size() != 0 || n != list.size()) begin
            failures++;
            $display("FAIL b2b_drain granted=%0d pending=%0d expected granted=%0d pending=0",
                     n, sb.size(), list.size());
        end
    endtask

    task automatic test_gnt_delay();
        logic [31:0] sb [$];
        logic        exp_g;
        logic        exp_rv;
        @(posedge clk); #1;
        for (int c = 0; c < 22; c++) begin
            req[1]   = (c <= 7) || (c == 10) || (c == 11) || (c >= 13 && c <= 16);
            we[1]    = (c <= 3);
            addr[1]  = 32'h0000_0008;
            be[1]    = 4'hF;
            wdata[1] = 32'hCAFE_F00D;
            @(negedge clk);
            exp_g  = (c == 3) || (c == 7) || (c == 16);
            exp_rv = (c == 4) || (c == 8) || (c == 17);
            checks++;
            if (gnt[1] !== exp_g) begin
                failures++;
                $display("FAIL gnt_delay_gnt cycle=%0d got=%b expected=%b", c, gnt[1], exp_g);
            end
            checks++;
            if (rvalid[1] !== exp_rv) begin
                failures++;
                $display("FAIL gnt_delay_rvalid cycle=%0d got=%b expected=%b", c, rvalid[1], exp_rv);
            end
            if (exp_rv && sb.size() > 0) begin
                checks++;
                if (rdata[1] !== sb[0]) begin
                    failures++;
                    $display("FAIL gnt_delay_rdata cycle=%0d got=%h expected=%h", c, rdata[1], sb[0]);
                end
                void'(sb.pop_front());
            end
            if (req[1] && gnt[1]) sb.push_back(we[1] ? 32'h0 : 32'hCAFE_F00D);
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL gnt_delay_drain pending=%0d expected=0", sb.size());
        end
    endtask

    task automatic test_stall();
        sb_t         sbw [$];
        logic [31:0] sb  [$];
        int          n = 0;
        logic        exp_g;
        logic        exp_rv;
        @(posedge clk); #1;
        for (int c = 0; c < 8; c++) begin
            req[2] = (n < 4);
            we[2] = 1'b1; be[2] = 4'hF;
            if (req[2]) begin addr[2] = 32'(4 * n); wdata[2] = STALL_PAT[n]; end
            @(negedge clk);
            exp_rv = (sbw.size() > 0) && (sbw[0].due == c);
            checks++;
            if (rvalid[2] !== exp_rv || (exp_rv && rdata[2] !== 32'h0)) begin
                failures++;
                $display("FAIL stall_wr_resp cycle=%0d rvalid=%b rdata=%h expected rvalid=%b rdata=0",
                         c, rvalid[2], rdata[2], exp_rv);
            end
            if (exp_rv) void'(sbw.pop_front());
            if (req[2] && gnt[2]) begin
                sbw.push_back('{c + 3, 32'h0});
                n++;
            end
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        n = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 11; c++) begin
            stall[2] = (c == 1);
            req[2]   = (n < 4);
            we[2]    = 1'b0;
            addr[2]  = 32'(4 * n);
            @(negedge clk);
            exp_g  = (c == 0) || (c == 2) || (c == 3) || (c == 4);
            exp_rv = (c == 3) || (c == 5) || (c == 6) || (c == 7);
            checks++;
            if (gnt[2] !== exp_g) begin
                failures++;
                $display("FAIL stall_gnt cycle=%0d got=%b expected=%b", c, gnt[2], exp_g);
            end
            checks++;
            if (rvalid[2] !== exp_rv) begin
                failures++;
                $display("FAIL stall_rvalid cycle=%0d got=%b expected=%b", c, rvalid[2], exp_rv);
            end
            if (exp_rv && sb.size() > 0) begin
                checks++;
                if (rdata[2] !== sb[0]) begin
                    failures++;
                    $display("FAIL stall_rdata cycle=%0d got=%h expected=%h", c, rdata[2], sb[0]);
                end
                void'(sb.pop_front());
            end
            if (req[2] && gnt[2]) begin
                sb.push_back(STALL_PAT[n]);
                n++;
            end
            @(posedge clk); #1;
        end
        req[2] = 1'b0; stall[2] = 1'b0;
        checks++;
        if (sb.size() != 0 || sbw.size() != 0) begin
            failures++;
            $display("FAIL stall_drain pending=%0d/%0d expected=0/0", sb.size(), sbw.size());
        end
    endtask

    task automatic test_out_of_range();
        xfer_t list [$];
        sb_t   sb [$];
        int    n = 0;
        logic  exp_rv;
        list.push_back('{32'h0000_0000, 1'b1, 4'hF, 32'h5555_AAAA, 32'h0});
        list.push_back('{32'h0000_003C, 1'b1, 4'hF, 32'h0F0F_0F0F, 32'h0});
        list.push_back('{32'h0000_0040, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF});
        list.push_back('{32'h0000_0040, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0});
        list.push_back('{32'h0000_0000, 1'b0, 4'hF, 32'h0,         32'h5555_AAAA});
        list.push_back('{32'h0000_003C, 1'b0, 4'hF, 32'h0,         32'h0F0F_0F0F});
        list.push_back('{32'h8000_0000, 1'b0, 4'hF, 32'h0,         32'hDEAD_BEEF});
        list.push_back('{32'h8000_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0});
        list.push_back('{32'h0000_0000, 1'b0, 4'hF, 32'h0,         32'h5555_AAAA});
        @(posedge clk); #1;
        for (int c = 0; c < 16; c++) begin
            req[3] = (n < list.size());
            if (req[3]) begin
                addr[3] = list[n].addr; we[3] = list[n].we;
                be[3] = list[n].be; wdata[3] = list[n].wdata;
            end
            @(negedge clk);
            exp_rv = (sb.size() > 0) && (sb[0].due == c);
            checks++;
            if (rvalid[3] !== exp_rv) begin
                failures++;
                $display("FAIL oor_rvalid cycle=%0d got=%b expected=%b", c, rvalid[3], exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (rdata[3] !== sb[0].data) begin
                    failures++;
                    $display("FAIL oor_rdata cycle=%0d got=%h expected=%h", c, rdata[3], sb[0].data);
                end
                void'(sb.pop_front());
            end
            if (req[3] && gnt[3]) begin
                sb.push_back('{c + 4, list[n].exp});
                n++;
            end
            @(posedge clk); #1;
        end
        req[3] = 1'b0;
        checks++;
        if (sb.size() != 0 || n != list.size()) begin
            failures++;
            $display("FAIL oor_drain granted=%0d pending=%0d expected granted=%0d pending=0",
                     n, sb.size(), list.size());
        end
    endtask

    task automatic test_reset_midflight();
        logic exp_g;
        logic exp_rv;
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            rst_n[3] = !(c == 2 || c == 3);
            req[3]   = (c == 0) || (c == 2) || (c == 5);
            we[3]    = (c == 2);
            addr[3]  = 32'h0;
            be[3]    = 4'hF;
            wdata[3] = 32'h9999_9999;
            @(negedge clk);
            exp_g  = (c == 0) || (c == 5);
            exp_rv = (c == 9);
            checks++;
            if (gnt[3] !== exp_g) begin
                failures++;
                $display("FAIL midrst_gnt cycle=%0d got=%b expected=%b", c, gnt[3], exp_g);
            end
            checks++;
            if (rvalid[3] !== exp_rv) begin
                failures++;
                $display("FAIL midrst_rvalid cycle=%0d got=%b expected=%b", c, rvalid[3], exp_rv);
            end
            if (c == 2) begin
                checks++;
                if (rdata[3] !== 32'h0) begin
                    failures++;
                    $display("FAIL midrst_rdata_clear got=%h expected=00000000", rdata[3]);
                end
            end
            if (c == 9) begin
                checks++;
                if (rdata[3] !== 32'h5555_AAAA) begin
                    failures++;
                    $display("FAIL midrst_write_dropped got=%h expected=5555aaaa", rdata[3]);
                end
            end
            @(posedge clk); #1;
        end
        req[3] = 1'b0; we[3] = 1'b0; rst_n[3] = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gnt_delay();
        test_stall();
        test_out_of_range();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
